// File: rtl/sched_glifos.sv
// sched_glifos: maps VGA pixels onto the 16x32 glyph memory, double-buffers an
// 8-cell glyph string, blinks a cursor cell and pipelines the colour out (Rev 1.0).
`default_nettype none

module sched_glifos #(
  parameter logic [9:0]  X0           = 10'd256,
  parameter logic [9:0]  Y0           = 10'd224,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FONDO        = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic        wr_valid,
  input  logic [2:0]  wr_idx,
  input  logic [3:0]  wr_code,
  output logic        wr_ready,
  input  logic        cursor_en,
  input  logic [2:0]  cursor_idx,
  output logic [4:0]  rom_fila,
  output logic [3:0]  rom_glifo,
  output logic [3:0]  rom_col,
  input  logic [11:0] rom_pixel,
  output logic [11:0] rgb,
  output logic        video_on_o
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(BLINK_FRAMES - 1);

  logic [3:0] sombra_q [8];
  logic [3:0] activo_q [8];

  logic [CW-1:0] cnt_blink_q, cnt_blink_d;
  logic          fase_q, fase_d;

  logic [4:0]  rom_fila_q;
  logic [3:0]  rom_glifo_q, rom_col_q;
  logic        dentro_q, blanco_q, von_q;
  logic [11:0] rgb_q;
  logic        von_o_q;

  // Bounds are compared in 11 bits so windows near the top of the range never wrap.
  logic [10:0] w_x_ext, w_y_ext;
  logic        w_dentro;
  logic [6:0]  w_dx;
  logic [4:0]  w_dy;
  logic [2:0]  w_cell;
  logic [3:0]  w_glifo;
  logic        w_blanco;
  logic        w_wr_fire;

  assign w_x_ext  = {1'b0, pixel_x};
  assign w_y_ext  = {1'b0, pixel_y};
  assign w_dentro = (w_x_ext >= {1'b0, X0}) && (w_x_ext < ({1'b0, X0} + 11'd128)) &&
                    (w_y_ext >= {1'b0, Y0}) && (w_y_ext < ({1'b0, Y0} + 11'd32));

  // Only the low bits of each offset are ever used.
  assign w_dx     = pixel_x[6:0] - X0[6:0];
  assign w_dy     = pixel_y[4:0] - Y0[4:0];
  assign w_cell   = w_dx[6:4];
  assign w_glifo  = activo_q[w_cell];
  assign w_blanco = (w_glifo == 4'hF) || (cursor_en && (w_cell == cursor_idx) && !fase_q);

  assign wr_ready  = !reset && !frame_start;
  assign w_wr_fire = wr_valid && wr_ready;

  always_comb begin
    cnt_blink_d = cnt_blink_q;
    fase_d      = fase_q;
    if (frame_start) begin
      if (cnt_blink_q == C_CNT_MAX) begin
        cnt_blink_d = '0;
        fase_d      = !fase_q;
      end else begin
        cnt_blink_d = cnt_blink_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        sombra_q[i] <= 4'hF;
        activo_q[i] <= 4'hF;
      end
      cnt_blink_q <= '0;
      fase_q      <= 1'b1;
      rom_fila_q  <= '0;
      rom_col_q   <= '0;
      rom_glifo_q <= 4'hF;
      dentro_q    <= 1'b0;
      blanco_q    <= 1'b0;
      von_q       <= 1'b0;
      rgb_q       <= '0;
      von_o_q     <= 1'b0;
    end else begin
      if (w_wr_fire) sombra_q[wr_idx] <= wr_code;
      if (frame_start) begin
        for (int i = 0; i < 8; i++) activo_q[i] <= sombra_q[i];
      end
      cnt_blink_q <= cnt_blink_d;
      fase_q      <= fase_d;

      if (w_dentro) begin
        rom_fila_q  <= w_dy;
        rom_col_q   <= w_dx[3:0];
        rom_glifo_q <= w_glifo;
      end else begin
        rom_fila_q  <= '0;
        rom_col_q   <= '0;
        rom_glifo_q <= 4'hF;
      end
      dentro_q <= w_dentro;
      blanco_q <= w_blanco;
      von_q    <= video_on;

      rgb_q   <= !von_q ? 12'h000 : (!dentro_q ? 12'h000 : (blanco_q ? FONDO : rom_pixel));
      von_o_q <= von_q;
    end
  end

  assign rom_fila   = rom_fila_q;
  assign rom_col    = rom_col_q;
  assign rom_glifo  = rom_glifo_q;
  assign rgb        = rgb_q;
  assign video_on_o = von_o_q;

endmodule

`default_nettype wire

// File: tb/tb_sched_glifos.sv
// tb_sched_glifos: directed bench for sched_glifos with a small behavioural glyph memory.
`default_nettype none

module tb_sched_glifos;

  localparam logic [9:0]  X0    = 10'd256;
  localparam logic [9:0]  Y0    = 10'd224;
  localparam logic [11:0] FONDO = 12'h00F;
  localparam logic [11:0] ON    = 12'h0F0;
  localparam logic [11:0] OFF   = 12'h000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0, frame_start = 1'b0;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [3:0]  wr_code = '0;
  logic        wr_ready;
  logic        cursor_en = 1'b0;
  logic [2:0]  cursor_idx = '0;
  logic [4:0]  rom_fila;
  logic [3:0]  rom_glifo, rom_col;
  logic [11:0] rom_pixel;
  logic [11:0] rgb;
  logic        video_on_o;

  int n_pass = 0;
  int n_total = 0;

  sched_glifos #(.X0(X0), .Y0(Y0), .BLINK_FRAMES(2), .FONDO(FONDO)) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .wr_valid(wr_valid),
    .wr_idx(wr_idx), .wr_code(wr_code), .wr_ready(wr_ready),
    .cursor_en(cursor_en), .cursor_idx(cursor_idx), .rom_fila(rom_fila),
    .rom_glifo(rom_glifo), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .rgb(rgb), .video_on_o(video_on_o)
  );

  always #5 clk = !clk;

  // Glyph 0: hollow box, 1: colon, 2: solid box; anything else dark.
  function automatic logic [11:0] glyph_px(input logic [4:0] f, input logic [3:0] g, input logic [3:0] c);
    logic box, inner, dots;
    box   = (c >= 4'd2) && (c <= 4'd13) && (f >= 5'd2) && (f <= 5'd29);
    inner = (c >= 4'd5) && (c <= 4'd10) && (f >= 5'd6) && (f <= 5'd25);
    dots  = (c >= 4'd5) && (c <= 4'd10) && (((f >= 5'd6) && (f <= 5'd10)) || ((f >= 5'd20) && (f <= 5'd24)));
    case (g)
      4'h0:    return (box && !inner) ? 12'h0F0 : 12'h000;
      4'h1:    return dots ? 12'h0F0 : 12'h000;
      4'h2:    return box ? 12'h0F0 : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  always_comb rom_pixel = glyph_px(rom_fila, rom_glifo, rom_col);

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y, input logic von,
                       input logic [4:0] ef, input logic [3:0] eg, input logic [3:0] ec,
                       input logic [11:0] ergb);
    pixel_x = x; pixel_y = y; video_on = von;
    @(posedge clk); #1;
    chk({tag, ".fila"},  12'(rom_fila),  12'(ef));
    chk({tag, ".glifo"}, 12'(rom_glifo), 12'(eg));
    chk({tag, ".col"},   12'(rom_col),   12'(ec));
    @(posedge clk); #1;
    chk({tag, ".rgb"},   rgb, ergb);
    chk({tag, ".von"},   12'(video_on_o), 12'(von));
  endtask

  task automatic wr(input logic [2:0] idx, input logic [3:0] code);
    wr_valid = 1'b1; wr_idx = idx; wr_code = code;
    #1;
    chk("wr.ready", 12'(wr_ready), 12'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset defaults
    #1;
    chk("rst.wr_ready", 12'(wr_ready), 12'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst.rgb",   rgb, OFF);
    chk("rst.von",   12'(video_on_o), 12'd0);
    chk("rst.glifo", 12'(rom_glifo), 12'hF);
    reset = 1'b0;
    for (int i = 0; i < 8; i += 3)
      probe("sweep", X0 + 10'(16 * i + 5), Y0 + 10'd3, 1'b1, 5'd3, 4'hF, 4'd5, FONDO);

    // Write and commit
    wr(3'd0, 4'h2);
    probe("precommit", X0 + 10'd5, Y0 + 10'd3, 1'b1, 5'd3, 4'hF, 4'd5, FONDO);
    pixel_x = X0 + 10'd5; pixel_y = Y0 + 10'd3; video_on = 1'b1;
    frame();
    chk("commit_cycle.glifo", 12'(rom_glifo), 12'hF);
    @(posedge clk); #1;
    chk("commit_cycle.rgb", rgb, FONDO);
    probe("c0_r3c5", X0 + 10'd5, Y0 + 10'd3, 1'b1, 5'd3, 4'h2, 4'd5, ON);
    probe("c0_r0c0", X0, Y0, 1'b1, 5'd0, 4'h2, 4'd0, OFF);

    // Colon glyph in cell 3
    wr(3'd3, 4'h1);
    frame();
    probe("colon_on",  X0 + 10'd54, Y0 + 10'd8,  1'b1, 5'd8,  4'h1, 4'd6, ON);
    probe("colon_off", X0 + 10'd54, Y0 + 10'd12, 1'b1, 5'd12, 4'h1, 4'd6, OFF);

    // Write collides with frame_start
    wr_valid = 1'b1; wr_idx = 3'd1; wr_code = 4'h0; frame_start = 1'b1;
    #1;
    chk("blocked.ready", 12'(wr_ready), 12'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;
    #1;
    chk("retry.ready", 12'(wr_ready), 12'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    probe("c1_old", X0 + 10'd23, Y0 + 10'd10, 1'b1, 5'd10, 4'hF, 4'd7, FONDO);
    frame();
    probe("c1_inner", X0 + 10'd23, Y0 + 10'd10, 1'b1, 5'd10, 4'h0, 4'd7, OFF);
    probe("c1_ring",  X0 + 10'd21, Y0 + 10'd3,  1'b1, 5'd3,  4'h0, 4'd5, ON);

    // Window edges
    wr(3'd7, 4'h2);
    frame();
    probe("corner",   X0 + 10'd127, Y0 + 10'd31, 1'b1, 5'd31, 4'h2, 4'd15, OFF);
    probe("c7_lit",   X0 + 10'd125, Y0 + 10'd20, 1'b1, 5'd20, 4'h2, 4'd13, ON);
    probe("left_out", X0 - 10'd1,   Y0 + 10'd3,  1'b1, 5'd0,  4'hF, 4'd0,  OFF);
    probe("right_out",X0 + 10'd128, Y0 + 10'd3,  1'b1, 5'd0,  4'hF, 4'd0,  OFF);
    probe("below_out",X0 + 10'd5,   Y0 + 10'd32, 1'b1, 5'd0,  4'hF, 4'd0,  OFF);
    probe("above_out",X0 + 10'd5,   Y0 - 10'd1,  1'b1, 5'd0,  4'hF, 4'd0,  OFF);
    probe("von_off",  X0 + 10'd5,   Y0 + 10'd3,  1'b0, 5'd3,  4'h2, 4'd5,  OFF);

    // video_on delay: one-cycle pulse must emerge exactly two edges later
    pixel_x = X0 + 10'd5; pixel_y = Y0 + 10'd3;
    video_on = 1'b1;
    @(posedge clk); #1;
    video_on = 1'b0;
    chk("vdly.e1", 12'(video_on_o), 12'd0);
    @(posedge clk); #1;
    chk("vdly.e2", 12'(video_on_o), 12'd1);
    chk("vdly.e2rgb", rgb, ON);
    @(posedge clk); #1;
    chk("vdly.e3", 12'(video_on_o), 12'd0);

    // Reset mid-frame
    video_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst.ready", 12'(wr_ready), 12'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("midrst.rgb",   rgb, OFF);
    chk("midrst.von",   12'(video_on_o), 12'd0);
    chk("midrst.glifo", 12'(rom_glifo), 12'hF);
    reset = 1'b0;
    probe("postrst", X0 + 10'd5, Y0 + 10'd3, 1'b1, 5'd3, 4'hF, 4'd5, FONDO);

    // Blink: half-period of 2 frames on cell 2
    cursor_en = 1'b1; cursor_idx = 3'd2;
    wr(3'd2, 4'h2);
    wr(3'd3, 4'h1);
    frame();
    probe("blink_f1",  X0 + 10'd37, Y0 + 10'd3, 1'b1, 5'd3, 4'h2, 4'd5, ON);
    probe("other_f1",  X0 + 10'd54, Y0 + 10'd8, 1'b1, 5'd8, 4'h1, 4'd6, ON);
    frame();
    probe("blink_f2",  X0 + 10'd37, Y0 + 10'd3, 1'b1, 5'd3, 4'h2, 4'd5, FONDO);
    probe("other_f2",  X0 + 10'd54, Y0 + 10'd8, 1'b1, 5'd8, 4'h1, 4'd6, ON);
    frame();
    probe("blink_f3",  X0 + 10'd37, Y0 + 10'd3, 1'b1, 5'd3, 4'h2, 4'd5, FONDO);
    frame();
    probe("blink_f4",  X0 + 10'd37, Y0 + 10'd3, 1'b1, 5'd3, 4'h2, 4'd5, ON);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sched_glifos.md
# sched_glifos

Display scheduler for the 16×32 glyph memory (`MEMORIA_SP`).
- Converts the VGA pixel position into the memory's row, glyph and column addresses.
- Holds an 8-cell glyph string in double-buffered registers. The RTC controller writes them through a valid/ready handshake, and they commit only at frame start, so the display never tears.
- Blanks a selected cursor cell at a programmable blink rate for time editing.
- Registers the memory's colour output into a 2-cycle pipelined RGB stream, aligned with a delayed `video_on`.

## Interface
Parameters:
- `X0`, 10'd256: left pixel column of the glyph window.
- `Y0`, 10'd224: top pixel row of the glyph window.
- `BLINK_FRAMES`, 30: frames per blink half-period (≥1).
- `FONDO`, 12'h000: colour inside the window for blank cells.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system/pixel clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `pixel_x`  in  10  current pixel column.
- `pixel_y`  in  10  current pixel row.
- `video_on`  in  1  visible-area flag for `pixel_x`/`pixel_y`.
- `frame_start`  in  1  one-cycle pulse per frame, during vertical blanking.
- `wr_valid`  in  1  glyph write request.
- `wr_idx`  in  3  cell index 0..7 (0 = leftmost).
- `wr_code`  in  4  glyph code; 4'hF = blank.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `cursor_en`  in  1  enable cursor blink.
- `cursor_idx`  in  3  cell to blink.
- `rom_fila`  out  5  to memory `direccion` (glyph row 0..31).
- `rom_glifo`  out  4  to memory `rom` (glyph code).
- `rom_col`  out  4  to memory `direccion_data` (glyph column 0..15).
- `rom_pixel`  in  12  memory `data_out`; combinational from the `rom_*` outputs.
- `rgb`  out  12  pixel colour.
- `video_on_o`  out  1  `video_on` delayed 2 cycles.

## Operation
- **Window geometry.**
  - Inside when `X0 ≤ pixel_x < X0+128` and `Y0 ≤ pixel_y < Y0+32`.
  - `dx = pixel_x−X0`, `dy = pixel_y−Y0`; both subtractions are 10-bit.
  - Cell = `dx[6:4]`, column = `dx[3:0]`, row = `dy[4:0]`.
  - The comparisons must not wrap: `pixel_x < X0` is outside.
- **Registers.**
  - `sombra[0..7]` (shadow) and `activo[0..7]` (active), 4 bits each.
  - Reset value of both is 4'hF.
- **Write handshake.**
  - `wr_ready = !reset && !frame_start`, combinational.
  - On an accepted write, `sombra[wr_idx] <= wr_code`.
  - A write held during `frame_start` stays pending and is accepted next cycle. The requester must hold `wr_valid`, `wr_idx` and `wr_code` stable until accepted.
- **Commit.** On `frame_start`, `activo[i] <= sombra[i]` for all 8 cells, in the same edge.
- **Blink.**
  - Counter `cnt_blink`, range 0..`BLINK_FRAMES`−1, increments on each `frame_start`.
  - When it wraps to 0, phase `fase` toggles.
  - Reset: `cnt_blink` = 0, `fase` = 1 (visible).
- **Blank condition.** A pixel is blank when either:
  - `activo[cell]` = 4'hF, or
  - `cursor_en && cell == cursor_idx && fase == 0`.
- **Stage 1** (registered, address to memory):
  - Inside the window: `rom_fila <= row`, `rom_col <= col`, `rom_glifo <= activo[cell]`.
  - Outside the window: `rom_fila <= 0`, `rom_col <= 0`, `rom_glifo <= 4'hF`.
  - Also registered: `dentro_q`, `blanco_q`, `von_q`.
- **Stage 2** (registered):
  - `rgb <= !von_q ? 0 : (!dentro_q ? 0 : (blanco_q ? FONDO : rom_pixel))`.
  - `video_on_o <= von_q`.
- **Reset values.** `rgb` = 0, `video_on_o` = 0, `rom_fila` = 0, `rom_col` = 0, `rom_glifo` = 4'hF. All pipeline flags are 0.

## Timing
- **Latency.** A pixel presented in cycle n:
  - drives the `rom_*` outputs during cycle n+1;
  - appears on `rgb` and `video_on_o` after edge n+2.
- The memory is combinational and must settle within one clock.
- **Commit/blink edge.** `frame_start` updates the active registers, `cnt_blink` and `fase` on the same edge. Pixels sampled in that cycle use the pre-commit `activo` values.
- **Write during `frame_start`.** The write is not taken; the commit copies the old shadow.
- **Reset mid-frame.** Takes effect on the next edge:
  - both register banks clear to blank;
  - the pipeline flushes to 0 within 2 cycles;
  - `wr_ready` is 0 while `reset` is high.
- **Boundaries.**
  - `pixel_x = X0+127` → cell 7, column 15.
  - `pixel_x = X0+128` → outside.
  - `pixel_y = Y0+31` → row 31.
  - `pixel_y = Y0+32` → outside.

## Test plan
1. **Reset defaults.** Reset, then sweep the window with `video_on` = 1 → `rgb` = 0 on every pixel; `rom_glifo` = 4'hF everywhere.
2. **Write and commit.** Write cell 0 = 4'h2; check that until `frame_start` the cell stays blank. After the pulse, at `(X0+5, Y0+3)` → `rom_fila` = 3, `rom_col` = 5, `rom_glifo` = 2; `rgb` = 12'h0F0 two cycles later. At `(X0+0, Y0)` → `rgb` = 12'h000.
3. **Colon glyph.** Cell 3 = 4'h1, committed; at `(X0+48+6, Y0+8)` → `rgb` = 12'h0F0. At `(X0+48+6, Y0+12)` → 12'h000.
4. **Write blocked by commit.** Raise `wr_valid` (cell 1 = 4'h0) in the same cycle as `frame_start` → `wr_ready` = 0 that cycle and the write is accepted the next cycle. The cell appears only after the following `frame_start`.
5. **Blink.** `BLINK_FRAMES` = 2, `cursor_en` = 1, `cursor_idx` = 2, cell 2 = 4'h2 → the cell is visible for frames 0–1, blank (`FONDO`) for frames 2–3, and visible again at frame 4. Other cells are never blanked.
6. **Window edges.** At `pixel_x` = `X0`−1, `X0`+128 and `pixel_y` = `Y0`+32 → `rgb` = 0. With `video_on` = 0 inside the window → `rgb` = 0 and `video_on_o` = 0, exactly 2 cycles delayed.
